// File: rtl/pila_retorno.sv
// Return-address stack: call pushes PC+1, return reads the top combinationally and pops on the edge.
// Optional high-water-mark register enabled by defining PILA_RETORNO_HWM_EN.
module pila_retorno #(
    parameter int AW    = 10,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wesp,
    input  logic                     push,
    input  logic                     pop,
    input  logic [AW-1:0]            d,
    output logic [AW-1:0]            q,
    output logic                     empty,
    output logic                     full,
    output logic                     overflow,
    output logic                     underflow,
    output logic [$clog2(DEPTH):0]   hwm
);
    localparam int              SPW      = $clog2(DEPTH) + 1;
    localparam logic [SPW-1:0]  DEPTH_SP = SPW'(DEPTH);

    logic [AW-1:0]  mem_q [DEPTH];
    logic [SPW-1:0] sp_q, sp_d;
    logic           ovf_q, ovf_d;
    logic           unf_q, unf_d;
    logic           we;
    logic [SPW-2:0] top_idx;

    assign empty     = (sp_q == '0);
    assign full      = (sp_q == DEPTH_SP);
    assign overflow  = ovf_q;
    assign underflow = unf_q;
    // Index wraps to DEPTH-1 when sp==DEPTH; the empty case is masked below.
    assign top_idx   = sp_q[SPW-2:0] - 1'b1;
    assign q         = empty ? '0 : mem_q[top_idx];

    always_comb begin
        sp_d  = sp_q;
        ovf_d = ovf_q;
        unf_d = unf_q;
        we    = 1'b0;
        if (wesp && push && !pop) begin
            if (full) begin
                ovf_d = 1'b1;
            end else begin
                we   = 1'b1;
                sp_d = sp_q + 1'b1;
            end
        end else if (wesp && pop && !push) begin
            if (empty) unf_d = 1'b1;
            else       sp_d  = sp_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sp_q  <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            sp_q  <= sp_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    // Storage is deliberately not reset; sp gates what is visible.
    always_ff @(posedge clk) begin
        if (we) mem_q[sp_q[SPW-2:0]] <= d;
    end

`ifdef PILA_RETORNO_HWM_EN
    logic [SPW-1:0] hwm_q, hwm_d;

    assign hwm_d = (sp_d > hwm_q) ? sp_d : hwm_q;
    assign hwm   = hwm_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) hwm_q <= '0;
        else       hwm_q <= hwm_d;
    end
`else
    assign hwm = '0;
`endif

endmodule

// File: tb/tb_pila_retorno.sv
// Directed plus random bench for pila_retorno against a queue-based stack model.
module tb_pila_retorno;
    localparam int AW    = 10;
    localparam int DEPTH = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          wesp = 1'b0, push = 1'b0, pop = 1'b0;
    logic [AW-1:0] d = '0;
    logic [AW-1:0] q;
    logic          empty, full, overflow, underflow;
    logic [$clog2(DEPTH):0] hwm;

    int unsigned stk[$];
    bit          m_ovf, m_unf;
    int unsigned m_hwm;
    int          total = 0;
    int          passed = 0;

    pila_retorno #(.AW(AW), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .wesp(wesp), .push(push), .pop(pop), .d(d),
        .q(q), .empty(empty), .full(full), .overflow(overflow),
        .underflow(underflow), .hwm(hwm)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        stk.delete();
        m_ovf = 0;
        m_unf = 0;
        m_hwm = 0;
    endtask

    // Stack semantics straight from the operation rules.
    task automatic model_op(input logic w, input logic p, input logic o, input logic [AW-1:0] dv);
        if (w && p && !o) begin
            if (stk.size() == DEPTH) m_ovf = 1;
            else                     stk.push_back(int'(dv));
        end else if (w && o && !p) begin
            if (stk.size() == 0) m_unf = 1;
            else                 void'(stk.pop_back());
        end
        if (stk.size() > m_hwm) m_hwm = stk.size();
    endtask

    task automatic check_all(input string tag);
        int unsigned eq, eh;
        eq = (stk.size() == 0) ? 0 : stk[$];
`ifdef PILA_RETORNO_HWM_EN
        eh = m_hwm;
`else
        eh = 0;
`endif
        chk({tag, ".q"},         32'(q),         eq);
        chk({tag, ".empty"},     32'(empty),     32'(stk.size() == 0));
        chk({tag, ".full"},      32'(full),      32'(stk.size() == DEPTH));
        chk({tag, ".overflow"},  32'(overflow),  32'(m_ovf));
        chk({tag, ".underflow"}, 32'(underflow), 32'(m_unf));
        chk({tag, ".hwm"},       32'(hwm),       eh);
    endtask

    // Apply strobes, take one edge, advance the model, then check 1 time unit later.
    task automatic op(input string tag, input logic w, input logic p, input logic o,
                      input logic [AW-1:0] dv);
        wesp = w; push = p; pop = o; d = dv;
        @(posedge clk);
        model_op(w, p, o, dv);
        #1;
        wesp = 0; push = 0; pop = 0;
        check_all(tag);
    endtask

    initial begin
        model_reset();
        #12 reset = 1'b0;
        repeat (3) op("idle", 0, 0, 0, '0);
        chk("reset.q", 32'(q), 0);

        op("push10", 1, 1, 0, 10'h010);
        op("push20", 1, 1, 0, 10'h020);
        op("push30", 1, 1, 0, 10'h030);
        chk("top30", 32'(q), 32'h030);
        // Same-cycle visibility of the top on a return.
        wesp = 1; pop = 1; #1;
        chk("pop_q_before_edge", 32'(q), 32'h030);
        op("pop1", 1, 0, 1, '0);
        op("pop2", 1, 0, 1, '0);
        op("pop3", 1, 0, 1, '0);
        chk("empty_after3", 32'(empty), 1);

        for (int i = 1; i <= DEPTH; i++) op("fill", 1, 1, 0, AW'(i));
        chk("full_q", 32'(q), 8);
        op("push_full", 1, 1, 0, 10'h3FF);
        chk("ovf_set", 32'(overflow), 1);
        op("pop_from_full", 1, 0, 1, '0);
        chk("q_after_full_pop", 32'(q), 7);
        for (int i = 0; i < DEPTH - 1; i++) op("drain", 1, 0, 1, '0);

        op("pop_empty", 1, 0, 1, '0);
        chk("unf_set", 32'(underflow), 1);
        op("push55", 1, 1, 0, 10'h055);
        chk("q55", 32'(q), 32'h055);

        op("push_nowesp", 0, 1, 0, 10'h123);
        op("push_pop_both", 1, 1, 1, 10'h1AA);
        chk("q55_kept", 32'(q), 32'h055);

        op("push100", 1, 1, 0, 10'h100);
        op("push200", 1, 1, 0, 10'h200);
        // Async reset between edges with a push pending.
        wesp = 1; push = 1; d = 10'h2AB;
        #2 reset = 1'b1;
        #1;
        model_reset();
        check_all("async_reset");
        #1 reset = 1'b0;
        wesp = 0; push = 0;

        for (int i = 0; i < 400; i++) begin
            logic w, p, o;
            int   r;
            r = int'($urandom_range(0, 99));
            w = ($urandom_range(0, 3) != 0);
            // Phase bias drives the stack to both saturation points.
            if (((i / 40) % 2) == 0) begin p = (r < 70); o = (r >= 65); end
            else                     begin p = (r < 30); o = (r >= 25); end
            op("rand", w, p, o, AW'($urandom));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/pila_retorno.md
Name: pila_retorno

Overview:
- Hardware return-address stack for the single-cycle CPU.
- Sits directly downstream of the control unit and consumes its wesp/push/pop strobes.
- Call instruction: pushes the return address (PC+1) supplied by the PC path.
- Return instruction: exposes the top entry combinationally so the next-PC mux can select it in the same cycle, then pops it on the clock edge.

Parameters:
- AW, 10, address width of each stored entry (PC width).
- DEPTH, 8, number of entries; power of two, 2..64.

Ports:
- clk  input  1  system clock, rising-edge active
- reset  input  1  asynchronous, active-high reset
- wesp  input  1  stack write enable from control unit; push/pop ignored when low
- push  input  1  push request (call)
- pop  input  1  pop request (return)
- d  input  AW  return address to push (PC+1)
- q  output  AW  current top-of-stack entry, combinational
- empty  output  1  no entries held
- full  output  1  DEPTH entries held
- overflow  output  1  sticky: push attempted while full
- underflow  output  1  sticky: pop attempted while empty
- hwm  output  clog2(DEPTH)+1  high-water mark (see Optional Feature)

Behaviour:
- State:
  - sp: occupancy counter, clog2(DEPTH)+1 bits, range 0..DEPTH.
  - mem[0..DEPTH-1]: AW-bit storage.
- Reset (async, immediate on reset high):
  - sp=0, overflow=0, underflow=0, hwm=0.
  - Memory contents are not cleared.
  - Outputs after reset: q=0, empty=1, full=0.
- Derived outputs (combinational):
  - empty = (sp==0); full = (sp==DEPTH).
  - q = mem[sp-1] when not empty, else 0.
  - q reflects state before the clock edge, so a return uses the value in the same cycle it is popped.
- Operation decode on each rising clk edge:
  - wesp=0: no state change, regardless of push/pop.
  - wesp=1, push=1, pop=0, not full: mem[sp] <= d; sp <= sp+1.
  - wesp=1, push=1, pop=0, full: no write, sp unchanged, overflow <= 1.
  - wesp=1, pop=1, push=0, not empty: sp <= sp-1; memory untouched.
  - wesp=1, pop=1, push=0, empty: sp stays 0, underflow <= 1.
  - wesp=1, push=1, pop=1 (never issued by the control unit): no state change, no flag change.
- Sticky flags:
  - overflow/underflow clear only on reset.
  - Flags do not block further operations.
- Latency:
  - push: entry visible on q the cycle after the edge.
  - pop: new top visible on q the cycle after the edge.
- Width rules:
  - sp never wraps; saturates at 0 and DEPTH.
  - d is stored verbatim, no arithmetic.
- Reset asserted mid-operation: pending push/pop is discarded; state goes to reset values without waiting for clk.

Optional Feature:
- Macro: PILA_RETORNO_HWM_EN.
- Defined:
  - hwm register tracks the maximum sp reached since reset.
  - Updated on the same edge as sp: if the new sp > hwm then hwm <= new sp.
  - hwm never decreases except on reset (to 0).
- Not defined:
  - hwm tied to constant 0; no register inferred.
  - All other behaviour identical.

Test Plan:
- Reset, then idle 3 cycles -> q=0, empty=1, full=0, overflow=0, underflow=0, hwm=0.
- Push 0x010, 0x020, 0x030 (wesp=1, one per cycle) -> q=0x030, sp=3; then pop three times -> q=0x020, 0x010, 0; empty=1 after third pop; hwm=3 with macro, 0 without.
- DEPTH=8: push 0x001..0x008 -> full=1, q=0x008; push 0x3FF -> overflow=1, q still 0x008; pop -> q=0x007, full=0, overflow stays 1.
- Pop while empty -> underflow=1, empty=1, q=0; following push 0x055 succeeds, q=0x055, underflow still 1.
- Invalid strobes: push=1 with wesp=0 -> no change; push=pop=wesp=1 with q=0x055 -> sp, q and flags unchanged.
- Push 0x100, 0x200; assert reset asynchronously between edges -> q=0, empty=1, flags and hwm 0 immediately, before the next clk edge.
